// File: rtl/adder_ctrl_pkg.sv
// Shared constants, FSM state type and helpers for the adder arbiter.
package adder_ctrl_pkg;

  // Operand/sum width of the shared serial adder.
  localparam int ADD_WIDTH          = 381;
  // Default watchdog limit in WAIT cycles.
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Next round-robin position after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 32'sd1;
    return (nxt >= n) ? 32'sd0 : nxt;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr,
// searching upward with wrap. Returns one-hot grant, its index and a hit flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  // Scan priority positions ptr, ptr+1, ... and keep the first requester found.
  always_comb begin
    logic found;
    logic hit;
    gnt   = {NUM_REQ{1'b0}};
    idx   = {IDX_W{1'b0}};
    found = 1'b0;
    hit   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        hit    = !found && req[i] && (((int'(ptr) + k) % NUM_REQ) == i);
        gnt[i] = gnt[i] | hit;
        idx    = hit ? IDX_W'(i) : idx;
        found  = found | hit;
      end
    end
    any = found;
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one multi-cycle serial adder between NUM_REQ
// requesters. Latches the winner's operands, pulses add_start, waits for
// add_done and returns sum/carry/id on a valid/ready response channel.
// Optional build macro ADDER_TIMEOUT_EN adds a WAIT watchdog that answers
// with rsp_err=1 and a zero sum after TIMEOUT_CYCLES cycles without add_done.
module adder_arbiter
  import adder_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = ADD_WIDTH,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  output logic                     add_start,
  input  logic                     add_done,
  input  logic [WIDTH-1:0]         add_s,
  input  logic                     add_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     rsp_err,
  output logic                     busy
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("adder_arbiter: illegal parameter combination");
  end

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]    add_a_q, add_a_d;
  logic [WIDTH-1:0]    add_b_q, add_b_d;
  logic                add_start_q, add_start_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0]    rsp_sum_q, rsp_sum_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic                rsp_err_q, rsp_err_d;
  logic                busy_q, busy_d;

  logic [NUM_REQ-1:0]  gnt_s;
  logic [ID_W-1:0]     gnt_idx_s;
  logic                gnt_any_s;
  logic [WIDTH-1:0]    sel_a_s, sel_b_s;
  logic                timeout_hit_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_rr (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt_s),
    .idx (gnt_idx_s),
    .any (gnt_any_s)
  );

  // Grant is only offered while idle; other states never accept a request.
  assign req_ready = (state_q == ST_IDLE) ? gnt_s : {NUM_REQ{1'b0}};

  // One-hot operand mux selecting the granted requester's slices.
  always_comb begin
    sel_a_s = {WIDTH{1'b0}};
    sel_b_s = {WIDTH{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_a_s = gnt_s[i] ? req_a[i*WIDTH +: WIDTH] : sel_a_s;
      sel_b_s = gnt_s[i] ? req_b[i*WIDTH +: WIDTH] : sel_b_s;
    end
  end

`ifdef ADDER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Watchdog counter: cleared while issuing, counts each cycle spent in WAIT.
  always_comb begin
    case (state_q)
      ST_ISSUE: cnt_d = {CNT_W{1'b0}};
      ST_WAIT:  cnt_d = cnt_q + CNT_W'(1);
      default:  cnt_d = cnt_q;
    endcase
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle when add_done has not arrived.
  assign timeout_hit_s = (state_q == ST_WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // Main FSM next-state and datapath capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_start_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_carry_d = rsp_carry_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any_s) begin
          add_a_d     = sel_a_s;
          add_b_d     = sel_b_s;
          rsp_id_d    = gnt_idx_s;
          ptr_d       = ID_W'(wrap_inc(int'(gnt_idx_s), NUM_REQ));
          add_start_d = 1'b1;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (add_done) begin
          rsp_sum_d   = add_s;
          rsp_carry_d = add_carry;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (timeout_hit_s) begin
          rsp_sum_d   = {WIDTH{1'b0}};
          rsp_carry_d = 1'b0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // busy mirrors the registered state so it is high in every non-IDLE state.
  assign busy_d = (state_d != ST_IDLE);

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= {ID_W{1'b0}};
      add_a_q     <= {WIDTH{1'b0}};
      add_b_q     <= {WIDTH{1'b0}};
      add_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= {ID_W{1'b0}};
      rsp_sum_q   <= {WIDTH{1'b0}};
      rsp_carry_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_start_q <= add_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_start = add_start_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomized self-checking bench for adder_arbiter with a behavioural adder
// and a round-robin reference model kept in plain queues/arrays.
module tb_adder_arbiter;

  localparam int N   = 4;
  localparam int W   = 381;
  localparam int IDW = 2;
  localparam int TO  = 8;
  localparam int XW  = W + 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_a = '0;
  logic [N*W-1:0]   req_b = '0;
  logic [W-1:0]     add_a, add_b;
  logic             add_start;
  logic             add_done = 1'b0;
  logic [W-1:0]     add_s = '0;
  logic             add_carry = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [IDW-1:0]   rsp_id;
  logic [W-1:0]     rsp_sum;
  logic             rsp_carry;
  logic             rsp_err;
  logic             busy;

  adder_arbiter #(
    .NUM_REQ        (N),
    .WIDTH          (W),
    .ID_W           (IDW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_start (add_start),
    .add_done  (add_done),
    .add_s     (add_s),
    .add_carry (add_carry),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  bit           pend [N];
  int           mptr;
  bit           m_busy;
  int           q_id [$];
  logic [W-1:0] q_a [$];
  logic [W-1:0] q_b [$];
  int           order [$];
  bit           tmo_mode = 1'b0;
  bit           adder_on = 1'b1;
  int           rdy_mode = 1;
  int           cyc = 0, exp_start_cyc = -100;
  int           start_cnt = 0, resp_cnt = 0, start_cyc = 0, resp_cyc = 0;
  int           last_id;
  logic [W-1:0] last_sum;
  logic         last_carry;
  int           tests = 0, fails = 0;

  task automatic check(input string tag, input logic [XW-1:0] got, input logic [XW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [383:0] t;
    for (int i = 0; i < 12; i++) t[i*32 +: 32] = $urandom;
    return t[W-1:0];
  endfunction

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) r |= pend[i];
    return r;
  endfunction

  // Behavioural adder: sees add_start, answers 1..4 cycles later with a+b.
  int           cd = 0;
  logic [W:0]   ad_full;
  always begin
    @(posedge clk); #1;
    if (adder_on) begin
      add_done = 1'b0;
      if (!reset) begin
        cd = 0;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          add_done  = 1'b1;
          add_s     = ad_full[W-1:0];
          add_carry = ad_full[W];
        end
      end else if (add_start) begin
        ad_full = {1'b0, add_a} + {1'b0, add_b};
        cd      = $urandom_range(1, 4);
      end
    end
  end

  // One clock: drive inputs from the model, then check DUT against the model.
  task automatic cycle();
    logic [N-1:0] exp_rdy;
    logic [W:0]   full;
    int           g;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      req_valid[i]    = pend[i];
      req_a[i*W +: W] = opa[i];
      req_b[i*W +: W] = opb[i];
    end
    case (rdy_mode)
      1:       rsp_ready = 1'b1;
      2:       rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    check("busy", XW'(busy), XW'(m_busy));
    exp_rdy = '0;
    g = -1;
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && pend[(mptr + k) % N]) g = (mptr + k) % N;
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
    end
    check("req_ready", XW'(req_ready), XW'(exp_rdy));
    if (g >= 0) begin
      q_id.push_back(g);
      q_a.push_back(opa[g]);
      q_b.push_back(opb[g]);
      pend[g]       = 1'b0;
      mptr          = (g + 1) % N;
      m_busy        = 1'b1;
      exp_start_cyc = cyc + 1;
    end
    check("add_start", XW'(add_start), XW'(cyc == exp_start_cyc));
    if (add_start && q_id.size() > 0) begin
      start_cnt++;
      start_cyc = cyc;
      check("add_a", XW'(add_a), XW'(q_a[0]));
      check("add_b", XW'(add_b), XW'(q_b[0]));
    end
    if (rsp_valid) begin
      if (q_id.size() == 0) begin
        check("rsp_spurious", XW'(rsp_valid), XW'(0));
      end else begin
        full = tmo_mode ? '0 : ({1'b0, q_a[0]} + {1'b0, q_b[0]});
        check("rsp_id", XW'(rsp_id), XW'(q_id[0]));
        check("rsp_sum", XW'(rsp_sum), XW'(full[W-1:0]));
        check("rsp_carry", XW'(rsp_carry), XW'(full[W]));
        check("rsp_err", XW'(rsp_err), XW'(tmo_mode));
        if (rsp_ready) begin
          last_id    = rsp_id;
          last_sum   = rsp_sum;
          last_carry = rsp_carry;
          order.push_back(q_id[0]);
          void'(q_id.pop_front());
          void'(q_a.pop_front());
          void'(q_b.pop_front());
          resp_cnt++;
          resp_cyc = cyc;
          m_busy   = 1'b0;
        end
      end
    end
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n = 0;
    while (resp_cnt < target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, XW'(resp_cnt >= target), XW'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_add_a", XW'(add_a), XW'(0));
    check("rst_add_b", XW'(add_b), XW'(0));
    check("rst_add_start", XW'(add_start), XW'(0));
    check("rst_rsp_valid", XW'(rsp_valid), XW'(0));
    check("rst_rsp_id", XW'(rsp_id), XW'(0));
    check("rst_rsp_sum", XW'(rsp_sum), XW'(0));
    check("rst_rsp_carry", XW'(rsp_carry), XW'(0));
    check("rst_rsp_err", XW'(rsp_err), XW'(0));
    check("rst_busy", XW'(busy), XW'(0));
    check("rst_req_ready", XW'(req_ready), XW'(0));
    reset = 1'b1;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    mptr   = 0;
    m_busy = 1'b0;
    q_id.delete();
    q_a.delete();
    q_b.delete();
    exp_start_cyc = -100;
  endtask

  initial begin
    int n;
    int s0;
    for (int i = 0; i < N; i++) begin
      opa[i]  = '0;
      opb[i]  = '0;
      pend[i] = 1'b0;
    end
    do_reset();

    // Single request from requester 2: 5 + 7
    rdy_mode = 1;
    opa[2] = W'(5);
    opb[2] = W'(7);
    pend[2] = 1'b1;
    s0 = start_cnt;
    run_until(resp_cnt + 1, 50, "single_done");
    check("single_starts", XW'(start_cnt - s0), XW'(1));
    check("single_id", XW'(last_id), XW'(2));
    check("single_sum", XW'(last_sum), XW'(12));
    check("single_carry", XW'(last_carry), XW'(0));

    // Overflow: all-ones + 1 wraps to zero with carry
    opa[1] = '1;
    opb[1] = W'(1);
    pend[1] = 1'b1;
    run_until(resp_cnt + 1, 50, "ovf_done");
    check("ovf_sum", XW'(last_sum), XW'(0));
    check("ovf_carry", XW'(last_carry), XW'(1));

    // All four at once after reset: served 0,1,2,3
    do_reset();
    order.delete();
    for (int i = 0; i < N; i++) begin
      opa[i]  = rand_op();
      opb[i]  = rand_op();
      pend[i] = 1'b1;
    end
    run_until(resp_cnt + 4, 200, "all4_done");
    for (int i = 0; i < N; i++) begin
      check("all4_order", XW'(order.size() > i ? order[i] : -1), XW'(i));
    end

    // Backpressure: response held for 10 cycles, another requester waiting
    rdy_mode = 2;
    opa[3] = rand_op(); opb[3] = rand_op(); pend[3] = 1'b1;
    opa[0] = rand_op(); opb[0] = rand_op(); pend[0] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 30) begin
      cycle();
      n++;
    end
    check("bp_rsp_seen", XW'(rsp_valid), XW'(1));
    s0 = resp_cnt;
    for (int i = 0; i < 10; i++) cycle();
    check("bp_held_valid", XW'(rsp_valid), XW'(1));
    check("bp_no_consume", XW'(resp_cnt - s0), XW'(0));
    rdy_mode = 1;
    run_until(s0 + 2, 100, "bp_release");

    // Randomized traffic with random backpressure
    rdy_mode = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          opa[i]  = ($urandom_range(0, 7) == 0) ? '1 : rand_op();
          opb[i]  = rand_op();
        end
      end
      cycle();
    end
    n = 0;
    while ((any_pend() || m_busy) && n < 400) begin
      cycle();
      n++;
    end
    check("rand_drain", XW'(n < 400), XW'(1));

    // Reset in the middle of WAIT, then a late add_done
    rdy_mode = 1;
    adder_on = 1'b0;
    opa[1] = rand_op(); opb[1] = rand_op(); pend[1] = 1'b1;
    s0 = start_cnt;
    n = 0;
    while (start_cnt == s0 && n < 20) begin
      cycle();
      n++;
    end
    check("midwait_started", XW'(start_cnt - s0), XW'(1));
    for (int i = 0; i < 3; i++) cycle();
    do_reset();
    @(posedge clk); #1;
    add_s     = '1;
    add_carry = 1'b1;
    add_done  = 1'b1;
    @(posedge clk); #1;
    add_done  = 1'b0;
    check("late_done_valid", XW'(rsp_valid), XW'(0));
    check("late_done_busy", XW'(busy), XW'(0));
    for (int i = 0; i < 3; i++) cycle();
    adder_on = 1'b1;
    order.delete();
    for (int i = 0; i < N; i++) begin
      opa[i]  = rand_op();
      opb[i]  = rand_op();
      pend[i] = 1'b1;
    end
    run_until(resp_cnt + 4, 200, "post_rst_done");
    check("post_rst_first", XW'(order.size() > 0 ? order[0] : -1), XW'(0));

    // Adder never answers
    adder_on = 1'b0;
    opa[0] = rand_op(); opb[0] = rand_op(); pend[0] = 1'b1;
`ifdef ADDER_TIMEOUT_EN
    tmo_mode = 1'b1;
    run_until(resp_cnt + 1, 60, "tmo_done");
    check("tmo_latency", XW'(resp_cyc - start_cyc), XW'(TO + 1));
    tmo_mode = 1'b0;
    adder_on = 1'b1;
    opa[2] = rand_op(); opb[2] = rand_op(); pend[2] = 1'b1;
    run_until(resp_cnt + 1, 50, "after_tmo_done");
`else
    for (int i = 0; i < 100; i++) cycle();
    check("no_tmo_valid", XW'(rsp_valid), XW'(0));
    check("no_tmo_busy", XW'(busy), XW'(1));
    check("no_tmo_err", XW'(rsp_err), XW'(0));
    adder_on = 1'b1;
    do_reset();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one multi-cycle 381-bit serial adder (start/done handshake, result on S/carry) between NUM_REQ requesters.
- Round-robin selects one pending request, latches its operands and pulses the adder's start.
- Waits for done, then returns sum, carry and requester ID on a single valid/ready response channel.
- Sits between client blocks (e.g. modular-arithmetic engines) and the adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 381, operand/sum width; must match the adder.
- ID_W, 2, width of rsp_id; must be ≥ clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with ADDER_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  in  NUM_REQ*WIDTH  flattened operand A; slice i = [i*WIDTH +: WIDTH].
- req_b  in  NUM_REQ*WIDTH  flattened operand B.
- add_a  out  WIDTH  operand A to adder.
- add_b  out  WIDTH  operand B to adder.
- add_start  out  1  one-cycle start pulse to adder.
- add_done  in  1  adder result valid.
- add_s  in  WIDTH  adder sum.
- add_carry  in  1  adder carry-out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the served requester.
- rsp_sum  out  WIDTH  captured sum.
- rsp_carry  out  1  captured carry.
- rsp_err  out  1  timeout flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0 at a clk edge): state=IDLE, rr pointer=0, and every registered output is 0: add_a, add_b, add_start, rsp_valid, rsp_id, rsp_sum, rsp_carry, rsp_err, busy. Reset overrides everything, including mid-WAIT; an in-flight request is dropped without a response.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant g = first i with req_valid[i] set, searching from pointer upward with wrap.
  - req_ready[g]=1 (combinational, only in IDLE); all other bits 0.
  - On handshake: latch req_a/req_b slice g into add_a/add_b, latch g into rsp_id, set pointer = (g+1) mod NUM_REQ, go to ISSUE.
  - With no req_valid set, stay in IDLE.
- ISSUE: add_start=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - add_a/add_b held stable from ISSUE until leaving WAIT.
  - On the first cycle add_done=1: capture add_s into rsp_sum and add_carry into rsp_carry, set rsp_err=0, go to RESP.
  - add_done is ignored in IDLE, ISSUE and RESP.
- RESP:
  - rsp_valid=1; rsp_* held stable until rsp_ready=1.
  - On rsp_ready=1, go to IDLE; rsp_valid drops the next cycle.
  - A new grant is possible in that same IDLE cycle.
- Latency: handshake at edge T → add_start high in cycle T+1 → rsp_valid rises the cycle after the edge that samples add_done=1.
- A requester holding req_valid across a grant is served again only after the other pending requesters (fairness).
- Simultaneous req_valid on all inputs: service order follows the pointer, e.g. 0,1,2,3.
- Width rule: the sum is modulo 2^WIDTH; the carry comes from the adder only. The arbiter performs no arithmetic.

Optional Feature:
- ADDER_TIMEOUT_EN defined:
  - Counter cleared on ISSUE, incremented each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with add_done still 0: go to RESP with rsp_err=1, rsp_sum=0, rsp_carry=0.
  - Any later add_done is ignored until the next ISSUE.
- ADDER_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; rsp_err is constant 0.

Decomposition:
- Package adder_ctrl_pkg: WIDTH constant 381, state enum {IDLE, ISSUE, WAIT, RESP}, default TIMEOUT_CYCLES.
- Sub-module rr_arbiter: inputs NUM_REQ request vector and pointer; outputs one-hot grant and binary index. Purely combinational, reused elsewhere.

Test Plan:
- Single request: req 2 with A=5, B=7 → add_start pulses once; adder model returns 12 → rsp_valid, rsp_id=2, rsp_sum=12, rsp_carry=0.
- Overflow: A=2^381−1, B=1 → rsp_sum=0, rsp_carry=1.
- All four requesters valid together, each with distinct operands → responses in ID order 0,1,2,3 with correct sums, and no requester starved.
- Backpressure: rsp_ready held 0 for 10 cycles → rsp_* stable, no new req_ready, then one response consumed on release.
- Reset asserted mid-WAIT → all outputs 0 next cycle, late add_done ignored, pointer restarts at 0.
- With ADDER_TIMEOUT_EN and TIMEOUT_CYCLES=8, add_done never asserted → rsp_err=1 after 8 WAIT cycles, rsp_sum=0. Without the macro: no response and busy stays 1.
